// File: rtl/pz_frame_sequencer_pkg.sv
// Shared types and constants for the zero/pole frame sequencer.
// Latency: n/a (declarations plus one combinational helper).
// Backpressure: n/a.
package pz_frame_sequencer_pkg;

  localparam int NUM_COEF  = 8;
  localparam int COMP_W    = 16;
  localparam int IDX_W     = $clog2(NUM_COEF);

  // Index split: active/shadow 0-3 are zeroes and 4-7 are poles.
  // Host write indices at or above DELTA_BASE address the delta bank.
  localparam int         ZERO_BASE  = 0;
  localparam int         POLE_BASE  = 4;
  localparam logic [3:0] DELTA_BASE = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_SWAP
  } state_t;

  typedef enum logic {
    MODE_LOAD,
    MODE_STEP
  } mode_t;

  // One coefficient entry, {re, im}, both signed.
  typedef struct packed {
    logic signed [COMP_W-1:0] re;
    logic signed [COMP_W-1:0] im;
  } coef_t;

  // Signed add with one guard bit, clamped to the COMP_W signed range.
  // The guard bit differing from the sign bit means the sum overflowed.
  function automatic logic signed [COMP_W-1:0] sat_add(
    input logic signed [COMP_W-1:0] a,
    input logic signed [COMP_W-1:0] b
  );
    logic signed [COMP_W:0] s;
    s = {a[COMP_W-1], a} + {b[COMP_W-1], b};
    if (s[COMP_W] != s[COMP_W-1]) begin
      sat_add = s[COMP_W] ? {1'b1, {(COMP_W-1){1'b0}}}
                          : {1'b0, {(COMP_W-1){1'b1}}};
    end else begin
      sat_add = s[COMP_W-1:0];
    end
  endfunction

endpackage

// File: rtl/pz_frame_sequencer_if.sv
// Host write port into the shadow/delta coefficient banks.
// Latency: accepted write lands in the bank on the next edge.
// Backpressure: wr_ready drops while a coefficient update is in flight.
interface pz_frame_sequencer_if;

  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_idx;
  logic [31:0] wr_data;

  modport master (
    output wr_valid,
    output wr_idx,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_idx,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/pz_frame_sequencer_sat_cadd.sv
// Saturating complex add of two {re, im} coefficient words.
// Latency: combinational.
// Backpressure: none.
module sat_cadd
  import pz_frame_sequencer_pkg::*;
(
  input  coef_t a,
  input  coef_t b,
  output coef_t y
);

  assign y.re = sat_add(a.re, b.re);
  assign y.im = sat_add(a.im, b.im);

endmodule

// File: rtl/pz_frame_sequencer.sv
// Sequences an 8-entry zero/pole coefficient update at each frame boundary.
// Latency: frame_done at edge t -> entries staged t+1..t+8 -> all swapped at t+9.
// Backpressure: host writes stall (wr_ready=0) while busy; frame_done while busy sets overrun.
module pz_frame_sequencer
  import pz_frame_sequencer_pkg::*;
#(
  parameter int FCNT_W = 16
) (
  input  logic                  out_stream_aclk,
  input  logic                  reset,
  input  logic                  frame_done,
  pz_frame_sequencer_if.slave   wr,
  input  logic                  commit,
  input  logic                  anim_en,
  output logic [31:0]           zero_0,
  output logic [31:0]           zero_1,
  output logic [31:0]           zero_2,
  output logic [31:0]           zero_3,
  output logic [31:0]           pole_0,
  output logic [31:0]           pole_1,
  output logic [31:0]           pole_2,
  output logic [31:0]           pole_3,
  output logic                  pending,
  output logic                  busy,
  output logic                  update_done,
  output logic                  overrun,
  output logic [FCNT_W-1:0]     frame_count
);

  coef_t            shadow  [NUM_COEF];
  coef_t            delta   [NUM_COEF];
  coef_t            staging [NUM_COEF];
  coef_t            active  [NUM_COEF];

  state_t           state;
  mode_t            mode;
  logic [IDX_W-1:0] idx;

  coef_t            step_a;
  coef_t            step_b;
  coef_t            step_y;
  logic             wr_fire;

  assign wr.wr_ready = !busy;
  assign wr_fire     = wr.wr_valid && !busy;

  // Animation operands follow the update index; active is stable during UPDATE.
  assign step_a = active[idx];
  assign step_b = delta[idx];

  sat_cadd u_sat_cadd (
    .a (step_a),
    .b (step_b),
    .y (step_y)
  );

  // Software-visible banks: shadow for committed loads, delta for animation.
  always_ff @(posedge out_stream_aclk) begin
    if (reset) begin
      for (int k = 0; k < NUM_COEF; k++) begin
        shadow[k] <= '0;
        delta[k]  <= '0;
      end
    end else if (wr_fire) begin
      if (wr.wr_idx >= DELTA_BASE) begin
        delta[wr.wr_idx[IDX_W-1:0]] <= wr.wr_data;
      end else begin
        shadow[wr.wr_idx[IDX_W-1:0]] <= wr.wr_data;
      end
    end
  end

  // Update FSM: stage one entry per cycle, then publish all entries in one edge.
  always_ff @(posedge out_stream_aclk) begin
    if (reset) begin
      state       <= ST_IDLE;
      mode        <= MODE_LOAD;
      idx         <= '0;
      pending     <= 1'b0;
      busy        <= 1'b0;
      update_done <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
      for (int k = 0; k < NUM_COEF; k++) begin
        staging[k] <= '0;
        active[k]  <= '0;
      end
    end else begin
      update_done <= 1'b0;

      if (frame_done) begin
        frame_count <= frame_count + FCNT_W'(1);
      end

      // A fresh commit always arms; it wins over the clear below so a commit
      // landing on the consuming frame_done carries to the next frame.
      if (commit) begin
        pending <= 1'b1;
      end

      if (frame_done && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (frame_done && pending) begin
            state <= ST_UPDATE;
            mode  <= MODE_LOAD;
            busy  <= 1'b1;
            idx   <= '0;
            if (!commit) begin
              pending <= 1'b0;
            end
          end else if (frame_done && anim_en) begin
            state <= ST_UPDATE;
            mode  <= MODE_STEP;
            busy  <= 1'b1;
            idx   <= '0;
          end
        end

        ST_UPDATE: begin
          staging[idx] <= (mode == MODE_LOAD) ? shadow[idx] : step_y;
          if (idx == IDX_W'(NUM_COEF - 1)) begin
            state <= ST_SWAP;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        ST_SWAP: begin
          for (int k = 0; k < NUM_COEF; k++) begin
            active[k] <= staging[k];
          end
          update_done <= 1'b1;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign zero_0 = active[ZERO_BASE + 0];
  assign zero_1 = active[ZERO_BASE + 1];
  assign zero_2 = active[ZERO_BASE + 2];
  assign zero_3 = active[ZERO_BASE + 3];
  assign pole_0 = active[POLE_BASE + 0];
  assign pole_1 = active[POLE_BASE + 1];
  assign pole_2 = active[POLE_BASE + 2];
  assign pole_3 = active[POLE_BASE + 3];

endmodule

// File: tb/tb_pz_frame_sequencer.sv
// Directed bench for the zero/pole frame sequencer.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: write stall and overrun exercised directly.
module tb_pz_frame_sequencer;

  logic        out_stream_aclk;
  logic        reset;
  logic        frame_done;
  logic        commit;
  logic        anim_en;
  logic [31:0] zero_0, zero_1, zero_2, zero_3;
  logic [31:0] pole_0, pole_1, pole_2, pole_3;
  logic        pending, busy, update_done, overrun;
  logic [15:0] frame_count;

  int total;
  int bad;

  pz_frame_sequencer_if wr_if ();

  pz_frame_sequencer dut (
    .out_stream_aclk (out_stream_aclk),
    .reset           (reset),
    .frame_done      (frame_done),
    .wr              (wr_if),
    .commit          (commit),
    .anim_en         (anim_en),
    .zero_0          (zero_0),
    .zero_1          (zero_1),
    .zero_2          (zero_2),
    .zero_3          (zero_3),
    .pole_0          (pole_0),
    .pole_1          (pole_1),
    .pole_2          (pole_2),
    .pole_3          (pole_3),
    .pending         (pending),
    .busy            (busy),
    .update_done     (update_done),
    .overrun         (overrun),
    .frame_count     (frame_count)
  );

  initial out_stream_aclk = 1'b0;
  always #5 out_stream_aclk = ~out_stream_aclk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge out_stream_aclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] idx, input logic [31:0] data);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_idx   = idx;
    wr_if.wr_data  = data;
    tick();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  // Leaves the bench 1 unit after edge t, where frame_done was sampled.
  task automatic pulse_frame();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  int busy_seen;
  int ud_pulses;
  int ud_at;

  initial begin
    total            = 0;
    bad              = 0;
    reset            = 1'b1;
    frame_done       = 1'b0;
    commit           = 1'b0;
    anim_en          = 1'b0;
    wr_if.wr_valid   = 1'b0;
    wr_if.wr_idx     = '0;
    wr_if.wr_data    = '0;

    // Reset state
    tick(2);
    chk("rst_zero_0", zero_0, 32'h0);
    chk("rst_pole_3", pole_3, 32'h0);
    chk("rst_pending", {31'b0, pending}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_overrun", {31'b0, overrun}, 32'h0);
    chk("rst_fcnt", {16'b0, frame_count}, 32'h0);
    chk("rst_wr_ready", {31'b0, wr_if.wr_ready}, 32'h1);
    reset = 1'b0;
    tick();

    // Idle frame: no pending, no animation
    pulse_frame();
    busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) busy_seen++;
      tick();
    end
    chk("idle_busy_seen", busy_seen, 0);
    chk("idle_fcnt", {16'b0, frame_count}, 32'd1);
    chk("idle_zero_0", zero_0, 32'h0);

    // Committed load with atomicity check
    wr(4'd0, 32'h0100_FF00);
    wr(4'd5, 32'h0040_0020);
    pulse_commit();
    chk("load_pending_set", {31'b0, pending}, 32'h1);
    pulse_frame();
    chk("load_pending_clr", {31'b0, pending}, 32'h0);
    chk("load_busy", {31'b0, busy}, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("atom_zero_0_t%0d", i), zero_0, 32'h0);
      chk($sformatf("atom_pole_1_t%0d", i), pole_1, 32'h0);
      chk($sformatf("atom_ud_t%0d", i), {31'b0, update_done}, 32'h0);
    end
    chk("load_busy_t8", {31'b0, busy}, 32'h1);
    tick();
    chk("load_zero_0", zero_0, 32'h0100_FF00);
    chk("load_pole_1", pole_1, 32'h0040_0020);
    chk("load_zero_1", zero_1, 32'h0);
    chk("load_ud_t9", {31'b0, update_done}, 32'h1);
    chk("load_busy_t9", {31'b0, busy}, 32'h0);
    tick();
    chk("load_ud_t10", {31'b0, update_done}, 32'h0);

    // Commit beats animation: plain load, no delta applied
    wr(4'd1, 32'h7FF0_8010);
    wr(4'd9, 32'h0020_FFE0);
    wr(4'd12, 32'h0001_FFFF);
    anim_en = 1'b1;
    pulse_commit();
    pulse_frame();
    tick(9);
    chk("prio_zero_1", zero_1, 32'h7FF0_8010);
    chk("prio_pole_0", pole_0, 32'h0);

    // Animation steps with saturation, frames 20 cycles apart
    pulse_frame();
    tick(9);
    chk("step1_zero_1", zero_1, 32'h7FFF_8000);
    chk("step1_pole_0", pole_0, 32'h0001_FFFF);
    chk("step1_zero_0", zero_0, 32'h0100_FF00);
    chk("step1_pole_1", pole_1, 32'h0040_0020);
    tick(10);
    pulse_frame();
    tick(9);
    chk("step2_zero_1", zero_1, 32'h7FFF_8000);
    chk("step2_pole_0", pole_0, 32'h0002_FFFE);
    chk("step2_fcnt", {16'b0, frame_count}, 32'd5);

    // Overrun, stalled write, commit while busy
    pulse_frame();
    tick(2);
    chk("stall_wr_ready", {31'b0, wr_if.wr_ready}, 32'h0);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_idx   = 4'd0;
    wr_if.wr_data  = 32'hAAAA_5555;
    tick();
    wr_if.wr_valid = 1'b0;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("ovr_set", {31'b0, overrun}, 32'h1);
    pulse_commit();
    chk("busy_commit_pending", {31'b0, pending}, 32'h1);
    ud_pulses = 0;
    ud_at     = 0;
    for (int j = 6; j <= 25; j++) begin
      tick();
      if (update_done) begin
        ud_pulses++;
        ud_at = j;
      end
    end
    chk("ovr_ud_pulses", ud_pulses, 1);
    chk("ovr_ud_edge", ud_at, 9);
    chk("ovr_fcnt", {16'b0, frame_count}, 32'd7);
    chk("ovr_pole_0", pole_0, 32'h0003_FFFD);

    // Pending commit from the busy window loads shadow; stalled write absent
    anim_en = 1'b0;
    pulse_frame();
    tick(9);
    chk("stall_zero_0", zero_0, 32'h0100_FF00);
    chk("reload_zero_1", zero_1, 32'h7FF0_8010);
    chk("reload_pole_0", pole_0, 32'h0);
    chk("reload_pending", {31'b0, pending}, 32'h0);

    // Retry the write after the update
    wr(4'd0, 32'hAAAA_5555);
    pulse_commit();
    pulse_frame();
    tick(9);
    chk("retry_zero_0", zero_0, 32'hAAAA_5555);
    chk("retry_fcnt", {16'b0, frame_count}, 32'd9);
    chk("ovr_sticky", {31'b0, overrun}, 32'h1);

    // Commit coincident with frame_done in IDLE waits for the next frame
    wr(4'd0, 32'h1234_5678);
    commit     = 1'b1;
    frame_done = 1'b1;
    tick();
    commit     = 1'b0;
    frame_done = 1'b0;
    chk("coinc_busy", {31'b0, busy}, 32'h0);
    chk("coinc_pending", {31'b0, pending}, 32'h1);

    // Reset mid-update aborts it
    pulse_frame();
    tick(3);
    chk("mid_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    tick();
    chk("mid_rst_zero_0", zero_0, 32'h0);
    chk("mid_rst_zero_1", zero_1, 32'h0);
    chk("mid_rst_overrun", {31'b0, overrun}, 32'h0);
    chk("mid_rst_fcnt", {16'b0, frame_count}, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    tick(12);
    chk("abort_zero_0", zero_0, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
